// File: rtl/circle_engine_if.sv
// Draw-request and pixel-plot signals between a circle requester and the engine.
interface circle_engine_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic                fill;
  logic [COLOUR_W-1:0] colour;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [R_W-1:0]      radius;
  logic                plot_ready;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, fill, colour, centre_x, centre_y, radius, plot_ready,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, fill, colour, centre_x, centre_y, radius, plot_ready,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle_engine.sv
// Midpoint-circle rasteriser: walks outline octants or filled spans, one
// candidate pixel per cycle, with screen clipping and plot back-pressure.
module circle_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int R_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           rst,
  circle_engine_if.slave bus
);
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int OW = R_W + 2;
  localparam int KW = R_W + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
  } coord_t;

  function automatic logic signed [CW-1:0] widen(input logic signed [OW-1:0] v);
    return CW'(v);
  endfunction

  // Spans 0/1 use the ox half-width, spans 2/3 use oy.
  function automatic logic signed [CW-1:0] span_lo(input logic [2:0] idx,
                                                   input logic signed [CW-1:0] cx,
                                                   input logic signed [CW-1:0] a,
                                                   input logic signed [CW-1:0] b);
    return idx[1] ? (cx - b) : (cx - a);
  endfunction

  function automatic logic signed [CW-1:0] span_hi(input logic [2:0] idx,
                                                   input logic signed [CW-1:0] cx,
                                                   input logic signed [CW-1:0] a,
                                                   input logic signed [CW-1:0] b);
    return idx[1] ? (cx + b) : (cx + a);
  endfunction

  function automatic coord_t candidate(input logic                 f,
                                       input logic [2:0]           idx,
                                       input logic signed [CW-1:0] sx,
                                       input logic signed [CW-1:0] cx,
                                       input logic signed [CW-1:0] cy,
                                       input logic signed [CW-1:0] a,
                                       input logic signed [CW-1:0] b);
    coord_t c;
    c = '0;
    if (f) begin
      c.x = sx;
      case (idx[1:0])
        2'd0:    c.y = cy + b;
        2'd1:    c.y = cy - b;
        2'd2:    c.y = cy + a;
        2'd3:    c.y = cy - a;
        default: c.y = cy;
      endcase
    end else begin
      case (idx)
        3'd0:    begin c.x = cx + a; c.y = cy + b; end
        3'd1:    begin c.x = cx + b; c.y = cy + a; end
        3'd2:    begin c.x = cx - a; c.y = cy + b; end
        3'd3:    begin c.x = cx - b; c.y = cy + a; end
        3'd4:    begin c.x = cx - a; c.y = cy - b; end
        3'd5:    begin c.x = cx - b; c.y = cy - a; end
        3'd6:    begin c.x = cx + a; c.y = cy - b; end
        3'd7:    begin c.x = cx + b; c.y = cy - a; end
        default: begin c.x = cx;     c.y = cy;     end
      endcase
    end
    return c;
  endfunction

  state_e                state_q, state_d;
  logic                  fill_q, fill_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;
  logic signed [CW-1:0]  cx_q, cx_d;
  logic signed [CW-1:0]  cy_q, cy_d;
  logic signed [OW-1:0]  ox_q, ox_d;
  logic signed [OW-1:0]  oy_q, oy_d;
  logic signed [KW-1:0]  crit_q, crit_d;
  logic [2:0]            idx_q, idx_d;
  logic signed [CW-1:0]  sx_q, sx_d;
  logic [X_W-1:0]        vga_x_q, vga_x_d;
  logic [Y_W-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  vga_plot_q, vga_plot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic signed [OW-1:0]  oy_new_s, ox_new_s;
  logic signed [KW-1:0]  crit_new_s;
  logic [2:0]            idx_next_s;
  logic                  advance_s;
  logic                  in_screen_s;
  coord_t                cand_s;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_q       <= 1'b0;
      colour_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      crit_q       <= '0;
      idx_q        <= 3'd0;
      sx_q         <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      crit_q       <= crit_d;
      idx_q        <= idx_d;
      sx_q         <= sx_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state, midpoint update and the candidate for the next cycle.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    colour_d   = colour_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    crit_d     = crit_q;
    idx_d      = idx_q;
    sx_d       = sx_q;
    idx_next_s = idx_q + 3'd1;
    advance_s  = (!vga_plot_q) || bus.plot_ready;

    oy_new_s = oy_q + OW'(1);
    if (crit_q[KW-1] || (crit_q == '0)) begin
      ox_new_s   = ox_q;
      crit_new_s = crit_q + (KW'(oy_new_s) <<< 1) + KW'(1);
    end else begin
      ox_new_s   = ox_q - OW'(1);
      crit_new_s = crit_q + ((KW'(oy_new_s) - KW'(ox_new_s)) <<< 1) + KW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          fill_d   = bus.fill;
          colour_d = bus.colour;
          cx_d     = $signed({{(CW-X_W){1'b0}}, bus.centre_x});
          cy_d     = $signed({{(CW-Y_W){1'b0}}, bus.centre_y});
          ox_d     = $signed({2'b00, bus.radius});
          oy_d     = '0;
          crit_d   = KW'(1) - $signed({3'b000, bus.radius});
          idx_d    = 3'd0;
          sx_d     = cx_d - widen(ox_d);
          state_d  = PLOT;
        end else begin
          state_d = IDLE;
        end
      end
      PLOT: begin
        if (!advance_s) begin
          state_d = PLOT;
        end else if (fill_q) begin
          if (sx_q != span_hi(idx_q, cx_q, widen(ox_q), widen(oy_q))) begin
            sx_d = sx_q + CW'(1);
          end else if (idx_q == 3'd3) begin
            state_d = STEP;
          end else begin
            idx_d = idx_next_s;
            sx_d  = span_lo(idx_next_s, cx_q, widen(ox_q), widen(oy_q));
          end
        end else begin
          if (idx_q == 3'd7) begin
            state_d = STEP;
          end else begin
            idx_d = idx_next_s;
          end
        end
      end
      STEP: begin
        oy_d   = oy_new_s;
        ox_d   = ox_new_s;
        crit_d = crit_new_s;
        idx_d  = 3'd0;
        sx_d   = cx_q - widen(ox_new_s);
        if (oy_new_s > ox_new_s) begin
          state_d = DONE;
        end else begin
          state_d = PLOT;
        end
      end
      DONE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    cand_s      = candidate(fill_d, idx_d, sx_d, cx_d, cy_d, widen(ox_d), widen(oy_d));
    in_screen_s = (!cand_s.x[CW-1]) && (!cand_s.y[CW-1]) &&
                  (cand_s.x < CW'(SCREEN_W)) && (cand_s.y < CW'(SCREEN_H));

    if (state_d == PLOT) begin
      vga_x_d    = cand_s.x[X_W-1:0];
      vga_y_d    = cand_s.y[Y_W-1:0];
      vga_plot_d = in_screen_s;
    end else begin
      vga_x_d    = vga_x_q;
      vga_y_d    = vga_y_q;
      vga_plot_d = 1'b0;
    end
    vga_colour_d = colour_d;
    busy_d       = (state_d == PLOT) || (state_d == STEP);
    done_d       = (state_d == DONE);
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_circle_engine.sv
// Directed scoreboard bench for circle_engine: a reference midpoint model queues
// expected plotted pixels, which are popped as the engine hands them off.
module tb_circle_engine;
  localparam int X_W = 8, Y_W = 7, R_W = 8, COLOUR_W = 3;
  localparam int SCREEN_W = 160, SCREEN_H = 120;

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  pix_t exp_q[$];

  circle_engine_if #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(COLOUR_W)) bus();

  circle_engine #(
    .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(COLOUR_W),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    pix_t p;
    if (x >= 0 && x < SCREEN_W && y >= 0 && y < SCREEN_H) begin
      p.x = x;
      p.y = y;
      exp_q.push_back(p);
    end
  endtask

  // Reference midpoint walk: queues visible pixels, returns busy-cycle count.
  task automatic model(input bit f, input int cx, input int cy, input int r, output int cycles);
    int ox, oy, crit, x, y, h, row;
    ox = r; oy = 0; crit = 1 - r; cycles = 0;
    do begin
      if (!f) begin
        for (int k = 0; k < 8; k++) begin
          case (k)
            0: begin x = cx + ox; y = cy + oy; end
            1: begin x = cx + oy; y = cy + ox; end
            2: begin x = cx - ox; y = cy + oy; end
            3: begin x = cx - oy; y = cy + ox; end
            4: begin x = cx - ox; y = cy - oy; end
            5: begin x = cx - oy; y = cy - ox; end
            6: begin x = cx + ox; y = cy - oy; end
            default: begin x = cx + oy; y = cy - ox; end
          endcase
          push(x, y);
          cycles++;
        end
      end else begin
        for (int s = 0; s < 4; s++) begin
          h = (s < 2) ? ox : oy;
          case (s)
            0: row = cy + oy;
            1: row = cy - oy;
            2: row = cy + ox;
            default: row = cy - ox;
          endcase
          for (int xx = cx - h; xx <= cx + h; xx++) begin
            push(xx, row);
            cycles++;
          end
        end
      end
      cycles++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  task automatic run_draw(input string name, input bit f, input int col, input int cx,
                          input int cy, input int r, input int stall_idx,
                          input int stall_len, input bit hold_start);
    int   exp_cycles, cycles, popped, stall_cnt, hold_x, hold_y;
    pix_t e;
    model(f, cx, cy, r, exp_cycles);
    bus.fill       = f;
    bus.colour     = COLOUR_W'(col);
    bus.centre_x   = X_W'(cx);
    bus.centre_y   = Y_W'(cy);
    bus.radius     = R_W'(r);
    bus.plot_ready = 1'b1;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start    = hold_start;
    bus.fill     = ~f;
    bus.colour   = ~bus.colour;
    bus.centre_x = bus.centre_x + 8'd7;
    bus.radius   = bus.radius + 8'd3;
    check({name, ".busy_after_start"}, bus.busy, 1);
    cycles = 0; popped = 0; stall_cnt = 0; hold_x = 0; hold_y = 0;
    while (bus.busy === 1'b1 && cycles < 2000) begin
      if (bus.vga_plot === 1'b1 && popped == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          hold_x = int'(bus.vga_x);
          hold_y = int'(bus.vga_y);
        end else begin
          check({name, ".stall_x"}, bus.vga_x, hold_x);
          check({name, ".stall_y"}, bus.vga_y, hold_y);
        end
        stall_cnt++;
        bus.plot_ready = 1'b0;
      end else begin
        bus.plot_ready = 1'b1;
        if (bus.vga_plot === 1'b1) begin
          check({name, ".plot_expected"}, int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({name, ".x"}, bus.vga_x, e.x);
            check({name, ".y"}, bus.vga_y, e.y);
            check({name, ".colour"}, bus.vga_colour, col);
          end
          popped++;
        end
      end
      cycles++;
      @(posedge clk); #1;
    end
    bus.plot_ready = 1'b1;
    check({name, ".cycles"}, cycles, exp_cycles + stall_len);
    check({name, ".stall_cycles"}, stall_cnt, stall_len);
    check({name, ".left_in_queue"}, exp_q.size(), 0);
    check({name, ".done"}, bus.done, 1);
    check({name, ".plot_in_done"}, bus.vga_plot, 0);
    if (hold_start) begin
      repeat (3) @(posedge clk);
      #1;
      check({name, ".done_held"}, bus.done, 1);
      check({name, ".no_redraw"}, bus.busy, 0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({name, ".idle_done"}, bus.done, 0);
    check({name, ".idle_busy"}, bus.busy, 0);
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0; bus.fill = 1'b0; bus.colour = '0; bus.centre_x = '0;
    bus.centre_y = '0; bus.radius = '0; bus.plot_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.plot", bus.vga_plot, 0);
    check("reset.x", bus.vga_x, 0);
    check("reset.y", bus.vga_y, 0);
    check("reset.colour", bus.vga_colour, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_draw("r0_outline", 1'b0, 2, 10, 10, 0, -1, 0, 1'b0);
    run_draw("r1_outline", 1'b0, 5, 80, 60, 1, -1, 0, 1'b0);
    run_draw("r1_fill", 1'b1, 3, 80, 60, 1, -1, 0, 1'b1);
    run_draw("r0_fill", 1'b1, 6, 20, 30, 0, -1, 0, 1'b0);
    run_draw("clip_origin", 1'b0, 1, 0, 0, 5, -1, 0, 1'b0);
    run_draw("backpressure", 1'b0, 5, 80, 60, 1, 1, 3, 1'b0);
    run_draw("clip_fill_corner", 1'b1, 7, 158, 118, 3, -1, 0, 1'b0);

    // Abort a radius-10 draw mid-way with reset.
    bus.fill = 1'b0; bus.colour = 3'd4; bus.centre_x = 8'd80; bus.centre_y = 7'd60;
    bus.radius = 8'd10; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.busy", bus.busy, 0);
    check("abort.plot", bus.vga_plot, 0);
    check("abort.done", bus.done, 0);
    check("abort.x", bus.vga_x, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort.quiet_plot", bus.vga_plot, 0);
    check("abort.quiet_busy", bus.busy, 0);
    run_draw("after_abort", 1'b0, 6, 80, 60, 2, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/circle_engine.md
Name: circle_engine

Overview:
- Parametrised midpoint-circle rasteriser: the next generation of our VGA circle drawer.
- Emits one candidate pixel per cycle toward the VGA framebuffer adapter.
- Adds over the previous drawer:
  - configurable coordinate and radius widths
  - screen clipping
  - filled-disc mode
  - honoured colour input
  - plot back-pressure
  - a clean start/done handshake

Parameters:
X_W, 8, width of x coordinates
Y_W, 7, width of y coordinates
R_W, 8, width of radius
COLOUR_W, 3, width of colour
SCREEN_W, 160, visible columns; plotted x is 0..SCREEN_W-1
SCREEN_H, 120, visible rows; plotted y is 0..SCREEN_H-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a draw; sampled only in IDLE
fill  in  1  0 = outline, 1 = filled disc; latched at start
colour  in  COLOUR_W  draw colour; latched at start
centre_x  in  X_W  centre column; latched at start
centre_y  in  Y_W  centre row; latched at start
radius  in  R_W  radius; latched at start
plot_ready  in  1  framebuffer accepts the pixel this cycle
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  high in DONE
vga_x  out  X_W  pixel column
vga_y  out  Y_W  pixel row
vga_colour  out  COLOUR_W  latched colour
vga_plot  out  1  pixel valid, i.e. in screen and to be written

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE.
  - busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - Applies from any state, including mid-draw; no further pixels are emitted.
- States: IDLE, PLOT, STEP, DONE.
- IDLE, start=1:
  - latch inputs.
  - set oy=0, ox=radius, crit=1-radius.
  - set octant/span index to 0.
  - go to PLOT. The first candidate pixel appears the next cycle.
- start while busy or in DONE: ignored.
- Arithmetic:
  - Candidate coordinates are computed signed, width max(X_W,Y_W)+2, so that centre±offset never wraps.
  - crit is signed, R_W+3 bits.
- PLOT, outline (fill=0):
  - Eight candidates in octant order 0..7:
    - (cx+ox, cy+oy)
    - (cx+oy, cy+ox)
    - (cx-ox, cy+oy)
    - (cx-oy, cy+ox)
    - (cx-ox, cy-oy)
    - (cx-oy, cy-ox)
    - (cx+ox, cy-oy)
    - (cx+oy, cy-ox)
  - Duplicates are emitted; they are not suppressed.
- PLOT, fill (fill=1): four horizontal spans, each walked left to right, one x per candidate:
  - row cy+oy, x from cx-ox to cx+ox
  - row cy-oy, x from cx-ox to cx+ox
  - row cy+ox, x from cx-oy to cx+oy
  - row cy-ox, x from cx-oy to cx+oy
- Clipping: a candidate with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H:
  - drives vga_plot=0.
  - still consumes exactly one cycle.
  - advances regardless of plot_ready.
- Back-pressure: while vga_plot=1 and plot_ready=0, vga_x, vga_y and vga_colour hold stable and the engine does not advance. A candidate advances on the cycle vga_plot and plot_ready are both 1.
- After the last candidate of an iteration: go to STEP (one cycle, vga_plot=0).
- STEP:
  - oy += 1.
  - If crit<=0: crit += 2*oy_new+1.
  - Else: ox -= 1, then crit += 2*(oy_new-ox_new)+1.
  - Then, if oy_new>ox_new go to DONE, else go to PLOT with index 0.
- DONE: done=1, busy=0; stay until start=0, then go to IDLE. A held start never triggers a second draw.
- radius=0: a single iteration. Outline emits 8 copies of the centre; fill emits 4 copies.

Test Plan:
1. Outline, radius=0 at (10,10), plot_ready=1 -> exactly 8 vga_plot cycles, all (10,10), then STEP, then done=1.
2. Outline, radius=1 at (80,60), colour=5 -> 16 plots over 2 iterations: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59), then (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59); vga_colour=5 throughout; done follows.
3. Fill, radius=1 at (80,60):
   - 20 candidates.
   - Iteration 1: rows 60,60 x=79..81; rows 61,59 x=80.
   - Iteration 2: rows 61,59,61,59 x=79..81.
   - All plotted.
4. Clip: outline, radius=5 at (0,0) -> no vga_plot with negative coordinate; the cycle count equals the unclipped count (iterations×9, including STEP); done asserted.
5. Back-pressure: radius=1 outline with plot_ready low for 3 cycles on the 2nd pixel -> (80,61) held stable for 4 cycles; total sequence unchanged.
6. Reset mid-draw at pixel 5 of radius=10 -> next cycle busy=0, vga_plot=0, done=0; a new start draws correctly from scratch.
